// File: rtl/state_control_param.sv
// Top-level iteration sequencer: parameter fetch, C/read/D fetch, optional Occ
// fetch, execute and write-back, with stall hold, abort, DONE exit and iteration count.
module state_control_param #(
  parameter int OCC_CYCLES = 2,
  parameter int EX_CYCLES  = 1,
  parameter int WB_CYCLES  = 1,
  parameter int CNT_W      = 8,
  parameter int ITER_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_start,
  input  logic              is_find,
  input  logic              is_get_data_in_Occ,
  input  logic              mem_ready,
  input  logic              is_finish,
  input  logic              abort,
  input  logic              clear,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  phase_cnt,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GET_PARAM  = 3'd1,
    GET_DATA_1 = 3'd2,
    GET_DATA_2 = 3'd3,
    GET_DATA_3 = 3'd4,
    EX         = 3'd5,
    WRITE_BACK = 3'd6,
    DONE       = 3'd7
  } state_t;

  // GET_DATA_2 carries OCC_CYCLES-1 of the Occ cycles; GET_DATA_3 carries the last one.
  localparam logic [CNT_W-1:0] OCC_LAST = CNT_W'(OCC_CYCLES - 2);
  localparam logic [CNT_W-1:0] EX_LAST  = CNT_W'(EX_CYCLES - 1);
  localparam logic [CNT_W-1:0] WB_LAST  = CNT_W'(WB_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    phase_q, phase_d;
  logic [ITER_W-1:0]   iter_q;
  logic                iter_inc;
  logic                done_q, busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d != IDLE) && (state_d != DONE);
      if (iter_inc && (iter_q != '1)) iter_q <= iter_q + ITER_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = '0;
    iter_inc = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else if (is_finish && (state_q != DONE)) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE:       if (is_start) state_d = GET_PARAM;
        GET_PARAM:  if (is_find) state_d = GET_DATA_1;
        GET_DATA_1: begin
          if (mem_ready) state_d = is_get_data_in_Occ ? GET_DATA_2 : EX;
          else           phase_d = phase_q;
        end
        GET_DATA_2: begin
          // Stalled cycles neither count nor advance.
          if (!mem_ready)              phase_d = phase_q;
          else if (phase_q == OCC_LAST) state_d = GET_DATA_3;
          else                          phase_d = phase_q + CNT_W'(1);
        end
        GET_DATA_3: begin
          if (mem_ready) state_d = EX;
          else           phase_d = phase_q;
        end
        EX: begin
          if (phase_q == EX_LAST) state_d = WRITE_BACK;
          else                    phase_d = phase_q + CNT_W'(1);
        end
        WRITE_BACK: begin
          if (phase_q == WB_LAST) begin
            state_d  = GET_PARAM;
            iter_inc = 1'b1;
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end
        DONE:       if (clear) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign phase_cnt = phase_q;
  assign iter_cnt  = iter_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: doc/state_control_param.md
Name: state_control_param

Overview:
- Parametrised successor to the accelerator's top-level iteration FSM.
- Sequences each search iteration: parameter fetch, C/read/D fetch, optional multi-cycle Occ fetch, execute, write-back.
- Adds the following over the previous generation:
  - configurable Occ, EX and write-back cycle counts;
  - memory-stall hold;
  - abort;
  - explicit DONE exit;
  - a completed-iteration counter.
- Drives the per-phase execution modules through a 3-bit state code that keeps the existing encoding.

Parameters:
- OCC_CYCLES, 2: total Occ fetch cycles (GET_DATA_2 + GET_DATA_3); legal range 2..2^CNT_W.
- EX_CYCLES, 1: cycles spent in EX; legal range 1..2^CNT_W.
- WB_CYCLES, 1: cycles spent in WRITE_BACK; legal range 1..2^CNT_W.
- CNT_W, 8: phase counter width.
- ITER_W, 16: iteration counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- is_start  in  1  start request; sampled in IDLE only.
- is_find  in  1  unfinished parameter found; sampled in GET_PARAM only.
- is_get_data_in_Occ  in  1  current iteration needs Occ data; sampled on the GET_DATA_1 exit cycle.
- mem_ready  in  1  memory data valid; low holds the GET_DATA_1/2/3 states.
- is_finish  in  1  all iterations complete; forces DONE.
- abort  in  1  forces IDLE from any state.
- clear  in  1  leave DONE to IDLE.
- state  out  3  current state code.
- phase_cnt  out  CNT_W  cycles elapsed in the current multi-cycle state.
- iter_cnt  out  ITER_W  completed iterations.
- done  out  1  high while state == DONE.
- busy  out  1  high when state is neither IDLE nor DONE.

Behaviour:
- State encoding: IDLE=0, GET_PARAM=1, GET_DATA_1=2, GET_DATA_2=3, GET_DATA_3=4, EX=5, WRITE_BACK=6, DONE=7.
- All outputs are registered.
- Reset (asynchronous, immediate on rst high): state=IDLE, phase_cnt=0, iter_cnt=0, done=0, busy=0.
- Priority per edge: rst > abort > is_finish > normal transitions.
- abort: next state IDLE and phase_cnt=0; iter_cnt is preserved.
- is_finish: in any state other than DONE, next state is DONE and phase_cnt=0.
- Transitions:
  - IDLE: is_start -> GET_PARAM; otherwise stay.
  - GET_PARAM: is_find -> GET_DATA_1; otherwise stay.
  - GET_DATA_1: stays while mem_ready=0. When mem_ready=1: is_get_data_in_Occ=1 -> GET_DATA_2; otherwise -> EX.
  - GET_DATA_2: lasts OCC_CYCLES-1 cycles in which mem_ready=1; cycles with mem_ready=0 do not count. After the last counted cycle -> GET_DATA_3.
  - GET_DATA_3: stays while mem_ready=0; -> EX on the first cycle with mem_ready=1.
  - EX: lasts exactly EX_CYCLES cycles, then -> WRITE_BACK. Not affected by stalls.
  - WRITE_BACK: lasts exactly WB_CYCLES cycles, then -> GET_PARAM. iter_cnt increments on this exit edge.
  - DONE: clear -> IDLE; otherwise stay. is_finish has no effect in DONE.
- phase_cnt:
  - Resets to 0 on every state change.
  - Increments on each cycle the state is held, except for stalled cycles in GET_DATA_1/2/3.
  - Stays 0 in IDLE, GET_PARAM and DONE.
  - Exit compare for the counted states is phase_cnt == N-1, where N is the state's cycle count.
- iter_cnt:
  - Saturates at 2^ITER_W-1; no wrap-around.
  - Cleared only by rst; clear and abort do not affect it.
- Default parameters reproduce the previous-generation cycle behaviour exactly when mem_ready is tied high.
- Simultaneous-event rules:
  - abort + is_finish in the same cycle -> IDLE.
  - is_finish in the WRITE_BACK exit cycle -> DONE, and iter_cnt does not increment.
  - clear outside DONE is ignored.
- rst asserted mid-iteration returns to IDLE asynchronously. On deassertion the FSM waits for is_start.

Test Plan:
- Defaults, mem_ready=1, is_start, is_find and is_get_data_in_Occ asserted -> state sequence 0,1,2,3,4,5,6,1; iter_cnt goes 0->1 on the 6->1 edge.
- OCC_CYCLES=4 with mem_ready low for 2 cycles midway through GET_DATA_2 -> GET_DATA_2 is held for 3+2=5 cycles (phase_cnt frozen during the stall), then GET_DATA_3 for 1 cycle, then EX.
- EX_CYCLES=3, WB_CYCLES=2, is_get_data_in_Occ=0 -> path 2->5 (phase_cnt 0,1,2) -> 6 (phase_cnt 0,1) -> 1.
- is_finish pulsed while in EX -> DONE next edge with done=1 and busy=0; is_start ignored while in DONE; clear -> IDLE; iter_cnt unchanged.
- abort and is_finish asserted together in GET_DATA_2 -> IDLE; rst asserted mid-clock-period in WRITE_BACK -> state=0 and iter_cnt=0 immediately, before the next edge.
- ITER_W=2, run 5 full iterations -> iter_cnt reads 1,2,3,3,3 (saturates at 3).
